transform_model_scheduler: RTL and testbench

- Sequences the transform pipeline (vertex shader, FIFO, vertex post-processor) across a list of models for one frame.
- For each model it:
  - reads that model's descriptor (vertex base address and vertex count);
  - fetches the model's MVP matrix and loads it into the vertex shader;
  - streams the model's vertices from vertex memory, honouring pipeline ready, and flags the final vertex;
  - waits for the shader's finished pulse before moving to the next model.
- Sits between the frame controller (start/done) and the transform pipeline's input ports.

---
 rtl/transform_model_scheduler.sv | 169 ++++++++++++++++
 tb/tb_transform_model_scheduler.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transform_model_scheduler.sv
// Transform-pipeline scheduler: walks the model list for one frame, loads each MVP and streams vertices.
// Optional stall counter output enabled by defining TMS_STALL_COUNTER_EN.
module transform_model_scheduler #(
    parameter int DATAWIDTH       = 24,
    parameter int ADDR_WIDTH      = 12,
    parameter int MODEL_IDX_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          i_start,
    input  logic [MODEL_IDX_WIDTH:0]      i_num_models,
    output logic [MODEL_IDX_WIDTH-1:0]    o_desc_addr,
    input  logic [ADDR_WIDTH-1:0]         i_desc_base,
    input  logic [ADDR_WIDTH-1:0]         i_desc_count,
    output logic                          o_mvp_req,
    input  logic signed [DATAWIDTH-1:0]   i_mvp_matrix [4][4],
    input  logic                          i_mvp_valid,
    output logic signed [DATAWIDTH-1:0]   o_mvp_matrix [4][4],
    output logic                          o_mvp_dv,
    output logic [ADDR_WIDTH-1:0]         o_vtx_addr,
    input  logic signed [DATAWIDTH-1:0]   i_vtx_data [3],
    input  logic                          i_pipe_ready,
    input  logic                          i_pipe_finished,
    output logic signed [DATAWIDTH-1:0]   o_vertex [3],
    output logic                          o_vertex_dv,
    output logic                          o_vertex_last,
    output logic [MODEL_IDX_WIDTH-1:0]    o_model_idx,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [3:0]                    o_dbg_state
`ifdef TMS_STALL_COUNTER_EN
    ,
    output logic [31:0]                   o_stall_cycles
`endif
);

    // Handshakes: o_mvp_req stays high until the cycle i_mvp_valid is seen; i_pipe_ready is
    // sampled only while waiting to issue a vertex read, and an issued read is always delivered.
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_DESC_RD  = 4'd1,
        S_DESC_LAT = 4'd2,
        S_MVP_REQ  = 4'd3,
        S_VTX_RD   = 4'd4,
        S_VTX_SEND = 4'd5,
        S_WAIT_FIN = 4'd6,
        S_NEXT     = 4'd7,
        S_DONE     = 4'd8
    } state_t;

    state_t                   state;
    logic [MODEL_IDX_WIDTH:0] num_models_q;
    logic [MODEL_IDX_WIDTH:0] model_idx_q;
    logic [MODEL_IDX_WIDTH:0] model_idx_nxt;
    logic [ADDR_WIDTH-1:0]    count_q;
    logic [ADDR_WIDTH-1:0]    vtx_idx_q;
    logic                     is_last;

    always_comb begin
        model_idx_nxt = model_idx_q + 1'b1;
        is_last       = (vtx_idx_q == (count_q - 1'b1));
    end

    assign o_desc_addr = model_idx_q[MODEL_IDX_WIDTH-1:0];
    assign o_model_idx = model_idx_q[MODEL_IDX_WIDTH-1:0];
    assign o_busy      = (state != S_IDLE);
    assign o_dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= S_IDLE;
            num_models_q  <= '0;
            model_idx_q   <= '0;
            count_q       <= '0;
            vtx_idx_q     <= '0;
            o_mvp_req     <= 1'b0;
            o_mvp_dv      <= 1'b0;
            o_vtx_addr    <= '0;
            o_vertex_dv   <= 1'b0;
            o_vertex_last <= 1'b0;
            o_done        <= 1'b0;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    o_mvp_matrix[r][c] <= '0;
            for (int k = 0; k < 3; k++)
                o_vertex[k] <= '0;
        end else begin
            o_mvp_dv      <= 1'b0;
            o_vertex_dv   <= 1'b0;
            o_vertex_last <= 1'b0;
            o_done        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        num_models_q <= i_num_models;
                        model_idx_q  <= '0;
                        state        <= (i_num_models == '0) ? S_DONE : S_DESC_RD;
                    end
                end
                S_DESC_RD: state <= S_DESC_LAT;
                S_DESC_LAT: begin
                    // The vertex address register always holds base + index, so the synchronous
                    // memory already has it during VTX_RD and returns data in VTX_SEND.
                    count_q    <= i_desc_count;
                    o_vtx_addr <= i_desc_base;
                    vtx_idx_q  <= '0;
                    if (i_desc_count == '0) begin
                        state <= S_NEXT;
                    end else begin
                        o_mvp_req <= 1'b1;
                        state     <= S_MVP_REQ;
                    end
                end
                S_MVP_REQ: begin
                    if (i_mvp_valid) begin
                        o_mvp_matrix <= i_mvp_matrix;
                        o_mvp_req    <= 1'b0;
                        o_mvp_dv     <= 1'b1;
                        state        <= S_VTX_RD;
                    end
                end
                S_VTX_RD: begin
                    if (i_pipe_ready)
                        state <= S_VTX_SEND;
                end
                S_VTX_SEND: begin
                    o_vertex    <= i_vtx_data;
                    o_vertex_dv <= 1'b1;
                    if (is_last) begin
                        o_vertex_last <= 1'b1;
                        state         <= S_WAIT_FIN;
                    end else begin
                        vtx_idx_q  <= vtx_idx_q + 1'b1;
                        o_vtx_addr <= o_vtx_addr + 1'b1;
                        state      <= S_VTX_RD;
                    end
                end
                S_WAIT_FIN: begin
                    if (i_pipe_finished)
                        state <= S_NEXT;
                end
                S_NEXT: begin
                    model_idx_q <= model_idx_nxt;
                    state       <= (model_idx_nxt == num_models_q) ? S_DONE : S_DESC_RD;
                end
                S_DONE: begin
                    o_done <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef TMS_STALL_COUNTER_EN
    // Cycles lost to pipeline backpressure or waiting for the shader to drain; saturating.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_stall_cycles <= '0;
        end else if (state == S_IDLE && i_start) begin
            o_stall_cycles <= '0;
        end else if (((state == S_VTX_RD && !i_pipe_ready) || state == S_WAIT_FIN)
                     && o_stall_cycles != 32'hFFFF_FFFF) begin
            o_stall_cycles <= o_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_transform_model_scheduler.sv
// Bench for transform_model_scheduler: directed scenarios plus randomized frames against a
// frame-level reference model (expected MVP/vertex event queues built from descriptors).
module tb_transform_model_scheduler;
    localparam int DW = 24;
    localparam int AW = 12;
    localparam int MW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn = 1'b0;

    logic                 i_start = 1'b0;
    logic [MW:0]          i_num_models = '0;
    logic [MW-1:0]        o_desc_addr;
    logic [AW-1:0]        i_desc_base = '0;
    logic [AW-1:0]        i_desc_count = '0;
    logic                 o_mvp_req;
    logic signed [DW-1:0] i_mvp_matrix [4][4];
    logic                 i_mvp_valid = 1'b0;
    logic signed [DW-1:0] o_mvp_matrix [4][4];
    logic                 o_mvp_dv;
    logic [AW-1:0]        o_vtx_addr;
    logic signed [DW-1:0] i_vtx_data [3];
    logic                 i_pipe_ready = 1'b1;
    logic                 i_pipe_finished = 1'b0;
    logic signed [DW-1:0] o_vertex [3];
    logic                 o_vertex_dv;
    logic                 o_vertex_last;
    logic [MW-1:0]        o_model_idx;
    logic                 o_busy;
    logic                 o_done;
    logic [3:0]           o_dbg_state;
`ifdef TMS_STALL_COUNTER_EN
    logic [31:0]          o_stall_cycles;
`endif

    transform_model_scheduler dut (
`ifdef TMS_STALL_COUNTER_EN
        .o_stall_cycles (o_stall_cycles),
`endif
        .clk            (clk),
        .rstn           (rstn),
        .i_start        (i_start),
        .i_num_models   (i_num_models),
        .o_desc_addr    (o_desc_addr),
        .i_desc_base    (i_desc_base),
        .i_desc_count   (i_desc_count),
        .o_mvp_req      (o_mvp_req),
        .i_mvp_matrix   (i_mvp_matrix),
        .i_mvp_valid    (i_mvp_valid),
        .o_mvp_matrix   (o_mvp_matrix),
        .o_mvp_dv       (o_mvp_dv),
        .o_vtx_addr     (o_vtx_addr),
        .i_vtx_data     (i_vtx_data),
        .i_pipe_ready   (i_pipe_ready),
        .i_pipe_finished(i_pipe_finished),
        .o_vertex       (o_vertex),
        .o_vertex_dv    (o_vertex_dv),
        .o_vertex_last  (o_vertex_last),
        .o_model_idx    (o_model_idx),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_dbg_state    (o_dbg_state)
    );

    // ---------------- environment state ----------------
    logic [DW-1:0] vmem [4096][3];
    logic [AW-1:0] desc_base [16];
    logic [AW-1:0] desc_count [16];
    logic [AW-1:0] desc_addr_q = '0;
    logic [AW-1:0] vtx_addr_q = '0;

    int unsigned mat_seed = 32'h1234_5678;
    int  mvp_hold = 1;
    int  fin_delay = 2;
    bit  rand_ready = 1'b0;
    bit  stall_arm = 1'b0;
    bit  spur_fin = 1'b0;
    int  stall_left = 0;
    int  fin_pend = 0;
    int  req_cyc = 0;
    int  req_total = 0;
    bit  ready_h1 = 1'b1, ready_h2 = 1'b1, prev_dv = 1'b0;

    int  cyc = 0, start_cyc = 0, first_dv_cyc = -1, fin_cyc = 0, done_cyc = 0;
    int  busy_cnt = 0, done_cnt = 0;
    int  dv_cyc_q [$];

    // ---------------- scoreboard ----------------
    logic [3:0]  exp_mvp_q [$];
    logic [76:0] exp_vtx_q [$];   // {model idx, last, x, y, z}
    logic [3:0]  m_pop;
    logic [76:0] e_pop;
    logic [3:0]  last_mvp_model = 4'hF;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mat_el(input int unsigned seed, input int idx,
                                             input int r, input int c);
        logic [31:0] h;
        h = seed ^ ((idx * 16 + r * 4 + c + 1) * 32'h9E37_79B1);
        h = h ^ (h >> 13);
        return h[DW-1:0];
    endfunction

    function automatic logic [383:0] exp_mat_flat(input int idx);
        logic [383:0] f;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                f[(r * 4 + c) * DW +: DW] = mat_el(mat_seed, idx, r, c);
        return f;
    endfunction

    function automatic logic [383:0] out_mat_flat();
        logic [383:0] f;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                f[(r * 4 + c) * DW +: DW] = o_mvp_matrix[r][c];
        return f;
    endfunction

    // ---------------- environment: memories, matrix source, pipeline, monitor ----------------
    always @(negedge clk) begin
        bit rdy;
        cyc++;
        if (rstn) begin
            if (i_start && !o_busy) begin
                start_cyc = cyc;
                first_dv_cyc = -1;
                busy_cnt = 0;
            end
            if (o_busy) busy_cnt++;
            if (o_mvp_dv) begin
                if (exp_mvp_q.size() == 0) begin
                    check("mvp_unexpected", 1, 0);
                end else begin
                    m_pop = exp_mvp_q.pop_front();
                    check("mvp_model_idx", o_model_idx, m_pop);
                    check("mvp_matrix", out_mat_flat(), exp_mat_flat(int'(m_pop)));
                    last_mvp_model = m_pop;
                end
            end
            if (o_vertex_last && !o_vertex_dv) check("last_without_dv", 1, 0);
            if (o_vertex_dv) begin
                check("vtx_ready_before_read", ready_h2, 1);
                check("vtx_spacing", prev_dv, 0);
                if (first_dv_cyc < 0) first_dv_cyc = cyc;
                dv_cyc_q.push_back(cyc);
                if (exp_vtx_q.size() == 0) begin
                    check("vtx_unexpected", 1, 0);
                end else begin
                    e_pop = exp_vtx_q.pop_front();
                    check("vtx_model_idx", o_model_idx, e_pop[76:73]);
                    check("vtx_after_mvp", last_mvp_model, e_pop[76:73]);
                    check("vtx_data_last",
                          {o_vertex_last, o_vertex[0], o_vertex[1], o_vertex[2]}, e_pop[72:0]);
                end
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        prev_dv = o_vertex_dv;

        // matrix source: valid in the mvp_hold-th cycle of a request
        if (o_mvp_req) begin
            req_cyc++;
            req_total++;
            i_mvp_valid = (req_cyc == mvp_hold);
        end else begin
            if (req_cyc > 0) check("mvp_req_len", req_cyc, mvp_hold);
            req_cyc = 0;
            i_mvp_valid = 1'b0;
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                i_mvp_matrix[r][c] = mat_el(mat_seed, int'(o_model_idx), r, c);

        // synchronous-read memories, one cycle of latency
        i_desc_base  = desc_base[desc_addr_q[3:0]];
        i_desc_count = desc_count[desc_addr_q[3:0]];
        desc_addr_q  = {{(AW-MW){1'b0}}, o_desc_addr};
        for (int k = 0; k < 3; k++) i_vtx_data[k] = vmem[vtx_addr_q][k];
        vtx_addr_q = o_vtx_addr;

        // shader: finished pulse fin_delay cycles after the last vertex
        i_pipe_finished = 1'b0;
        if (fin_pend > 0) begin
            fin_pend--;
            if (fin_pend == 0) begin
                i_pipe_finished = 1'b1;
                fin_cyc = cyc;
            end
        end
        if (o_vertex_dv && o_vertex_last) fin_pend = fin_delay;
        if (spur_fin && o_mvp_req) i_pipe_finished = 1'b1;

        // pipeline ready
        if (stall_arm && o_vertex_dv) begin
            stall_left = 5;
            stall_arm = 1'b0;
        end
        if (stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
        end else begin
            rdy = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        i_pipe_ready = rdy;
        ready_h2 = ready_h1;
        ready_h1 = rdy;
    end

    // ---------------- driver tasks ----------------
    task automatic build_exp(input int n);
        int a;
        logic [3:0] mi;
        for (int i = 0; i < n; i++) begin
            mi = i[3:0];
            if (desc_count[i] != '0) begin
                exp_mvp_q.push_back(mi);
                for (int j = 0; j < int'(desc_count[i]); j++) begin
                    a = (int'(desc_base[i]) + j) % 4096;
                    exp_vtx_q.push_back({mi, (j == int'(desc_count[i]) - 1),
                                         vmem[a][0], vmem[a][1], vmem[a][2]});
                end
            end
        end
    endtask

    task automatic pulse_start(input int n);
        @(posedge clk); #1;
        i_num_models = n[MW:0];
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_num_models = 5'($urandom_range(0, 16));
    endtask

    task automatic run_frame(input int n, input bit start_while_busy);
        int d0;
        dv_cyc_q.delete();
        build_exp(n);
        d0 = done_cnt;
        pulse_start(n);
        if (start_while_busy) begin
            repeat (3) @(posedge clk);
            #1;
            i_num_models = 5'd1;
            i_start = 1'b1;
            @(posedge clk); #1;
            i_start = 1'b0;
        end
        for (int t = 0; t < 6000 && done_cnt == d0; t++) @(posedge clk);
        check("done_seen", done_cnt - d0, 1);
        repeat (3) @(posedge clk);
        check("done_once", done_cnt - d0, 1);
        check("mvp_all_loaded", exp_mvp_q.size(), 0);
        check("vtx_all_sent", exp_vtx_q.size(), 0);
        check("idle_after_frame", o_busy, 0);
        exp_mvp_q.delete();
        exp_vtx_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r32;
        int n, d0, rq0;
        for (int a = 0; a < 4096; a++)
            for (int k = 0; k < 3; k++) begin
                r32 = $urandom;
                vmem[a][k] = r32[DW-1:0];
            end
        for (int i = 0; i < 16; i++) begin
            desc_base[i] = '0;
            desc_count[i] = '0;
        end

        // reset state
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_mvp_req", o_mvp_req, 0);
        check("rst_strobes", {o_mvp_dv, o_vertex_dv, o_vertex_last}, 0);
        check("rst_addrs", {o_vtx_addr, o_desc_addr, o_model_idx}, 0);
        check("rst_matrix", out_mat_flat(), 0);
        check("rst_vertex", {o_vertex[0], o_vertex[1], o_vertex[2]}, 0);
        rstn = 1'b1;

        // single model, base 0x010, three vertices, finished 2 cycles after last
        desc_base[0] = 12'h010;
        desc_count[0] = 12'd3;
        mat_seed = $urandom;
        run_frame(1, 1'b0);
        check("single_vertex_count", dv_cyc_q.size(), 3);
        check("lat_start_to_first_vtx", first_dv_cyc - start_cyc, 6);
        check("lat_finished_to_done", done_cyc - fin_cyc, 3);
`ifdef TMS_STALL_COUNTER_EN
        check("stall_single", o_stall_cycles, 3);
`endif

        // backpressure before the second vertex
        stall_arm = 1'b1;
        run_frame(1, 1'b0);
        check("bp_vertex_count", dv_cyc_q.size(), 3);
        if (dv_cyc_q.size() == 3) begin
            check("bp_gap_stalled", dv_cyc_q[1] - dv_cyc_q[0], 7);
            check("bp_gap_free", dv_cyc_q[2] - dv_cyc_q[1], 2);
        end
`ifdef TMS_STALL_COUNTER_EN
        check("stall_backpressure", o_stall_cycles, 8);
`endif

        // three models, counts 2/0/1, with an ignored start mid-frame
        desc_base[0] = 12'h100; desc_count[0] = 12'd2;
        desc_base[1] = 12'h200; desc_count[1] = 12'd0;
        desc_base[2] = 12'h300; desc_count[2] = 12'd1;
        mat_seed = $urandom;
        run_frame(3, 1'b1);
        check("three_model_vertices", dv_cyc_q.size(), 3);

        // zero models
        rq0 = req_total;
        run_frame(0, 1'b0);
        check("zero_busy_cycles", busy_cnt, 1);
        check("zero_done_latency", done_cyc - start_cyc, 2);
        check("zero_no_requests", req_total - rq0, 0);

        // delayed matrix
        mvp_hold = 4;
        desc_base[0] = 12'h040; desc_count[0] = 12'd2;
        run_frame(1, 1'b0);
        mvp_hold = 1;

        // reset during VTX_SEND aborts the frame
        desc_base[0] = 12'h500; desc_count[0] = 12'd4;
        dv_cyc_q.delete();
        build_exp(1);
        d0 = done_cnt;
        pulse_start(1);
        for (int t = 0; t < 200 && dv_cyc_q.size() == 0; t++) @(posedge clk);
        check("abort_first_vtx_seen", dv_cyc_q.size(), 1);
        #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", o_busy, 0);
        check("abort_strobes", {o_mvp_req, o_mvp_dv, o_vertex_dv, o_vertex_last, o_done}, 0);
        check("abort_addrs", {o_vtx_addr, o_desc_addr, o_model_idx}, 0);
        check("abort_matrix", out_mat_flat(), 0);
        check("abort_vertex", {o_vertex[0], o_vertex[1], o_vertex[2]}, 0);
        rstn = 1'b1;
        exp_mvp_q.delete();
        exp_vtx_q.delete();
        repeat (6) @(posedge clk);
        check("abort_no_done", done_cnt - d0, 0);

        // address wrap at the top of vertex memory
        desc_base[0] = 12'hFFF; desc_count[0] = 12'd2;
        run_frame(1, 1'b0);
        check("wrap_vertex_count", dv_cyc_q.size(), 2);

        // randomized frames
        rand_ready = 1'b1;
        spur_fin = 1'b1;
        for (int f = 0; f < 8; f++) begin
            n = (f == 7) ? 16 : $urandom_range(0, 5);
            for (int i = 0; i < 16; i++) begin
                desc_base[i] = 12'($urandom_range(0, 4095));
                desc_count[i] = 12'($urandom_range(0, (n == 16) ? 2 : 5));
            end
            mat_seed = $urandom;
            mvp_hold = $urandom_range(1, 4);
            fin_delay = $urandom_range(1, 4);
            run_frame(n, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
